// File: rtl/ir_modulator_tx_pkg.sv
// Shared types and carrier arithmetic for the IR modulator transmitter.
package ir_modulator_tx_pkg;

    localparam int SYM_LEN_MAX_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] div;
        logic [31:0] high;
    } carrier_cfg_t;

    // Symbol record; len is held at its widest and zero-extended from DUR_W.
    typedef struct packed {
        logic                     mark;
        logic [SYM_LEN_MAX_W-1:0] len;
    } sym_rec_t;

    function automatic carrier_cfg_t calc_carrier(input int clock_speed,
                                                  input int carrier_hz,
                                                  input int duty_pct);
        carrier_cfg_t cfg;
        cfg.div  = clock_speed / carrier_hz;
        cfg.high = (clock_speed / carrier_hz) * duty_pct / 100;
        return cfg;
    endfunction

endpackage

// File: rtl/ir_modulator_tx_fifo.sv
// Show-ahead synchronous symbol FIFO; pointers carry one extra wrap bit.
module ir_sym_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ir_sym_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ir_modulator_tx.sv
// IR transmitter: carrier generator gated by a queue of mark/space symbols
// measured in whole carrier periods.
module ir_modulator_tx
    import ir_modulator_tx_pkg::*;
#(
    parameter int CLOCK_SPEED = 8000000,
    parameter int CARRIER_HZ  = 38000,
    parameter int DUTY_PCT    = 33,
    parameter int DUR_W       = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mark,
    input  logic [DUR_W-1:0] in_len,
    output logic             sym_done,
    output logic             busy,
    output logic             out
);

    localparam carrier_cfg_t CFG = calc_carrier(CLOCK_SPEED, CARRIER_HZ, DUTY_PCT);
    localparam int DIV   = int'(CFG.div);
    localparam int HIGH  = int'(CFG.high);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(HIGH);

    generate
        if (DIV < 2 || HIGH < 1) begin : g_bad_carrier
            $error("ir_modulator_tx: carrier needs DIV >= 2 and HIGH >= 1");
        end
        if (DUTY_PCT < 1 || DUTY_PCT > 99) begin : g_bad_duty
            $error("ir_modulator_tx: DUTY_PCT must be within 1..99");
        end
        if (DUR_W < 1 || DUR_W > SYM_LEN_MAX_W) begin : g_bad_dur_w
            $error("ir_modulator_tx: DUR_W out of range");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    sym_rec_t         r_sym;
    sym_rec_t         w_head;
    logic [CNT_W-1:0] r_cnt;
    logic [DUR_W-1:0] r_per;
    logic             r_out;
    logic [DUR_W:0]   w_fifo_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_last;

    assign w_push   = in_valid && !w_full;
    assign in_ready = !w_full;

    ir_sym_fifo #(
        .WIDTH (DUR_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({in_mark, in_len}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head.mark = w_fifo_head[DUR_W];
    assign w_head.len  = SYM_LEN_MAX_W'(w_fifo_head[DUR_W-1:0]);

    // A zero-length symbol is its own last cycle.
    assign w_last = (r_sym.len == '0) ||
                    ((SYM_LEN_MAX_W'(r_per) == r_sym.len - SYM_LEN_MAX_W'(1)) &&
                     (r_cnt == CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && !w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    if (enable && !w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym <= '0;
            r_cnt <= '0;
            r_per <= '0;
            r_out <= 1'b0;
        end else begin
            if (w_pop) begin
                r_sym <= w_head;
                r_cnt <= '0;
                r_per <= '0;
            end else if (r_state == ST_RUN) begin
                if (r_cnt == CNT_MAX) begin
                    r_cnt <= '0;
                    r_per <= r_per + DUR_W'(1);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            r_out <= (r_state == ST_RUN) && r_sym.mark &&
                     (r_sym.len != '0) && (r_cnt < CNT_HIGH);
        end
    end

    assign sym_done = (r_state == ST_RUN) && w_last;
    assign busy     = (r_state == ST_RUN) || !w_empty;
    assign out      = r_out;

endmodule

// File: tb/tb_ir_modulator_tx.sv
// Directed and randomized checks of ir_modulator_tx against a waveform model.
module tb_ir_modulator_tx;

    localparam int CLOCK_SPEED = 1000;
    localparam int CARRIER_HZ  = 100;
    localparam int DUTY_PCT    = 30;
    localparam int DUR_W       = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int DIV         = 10;
    localparam int HIGH        = 3;

    typedef struct {
        bit mark;
        int len;
    } sym_t;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             enable   = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_mark  = 1'b0;
    logic [DUR_W-1:0] in_len   = '0;
    logic             in_ready;
    logic             sym_done;
    logic             busy;
    logic             out;

    int   checks   = 0;
    int   failures = 0;
    sym_t push_q[$];
    bit   exp_wave[$];

    ir_modulator_tx #(
        .CLOCK_SPEED (CLOCK_SPEED),
        .CARRIER_HZ  (CARRIER_HZ),
        .DUTY_PCT    (DUTY_PCT),
        .DUR_W       (DUR_W),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mark  (in_mark),
        .in_len   (in_len),
        .sym_done (sym_done),
        .busy     (busy),
        .out      (out)
    );

    always #5 clk = ~clk;

    function automatic sym_t mk(bit m, int l);
        sym_t r;
        r.mark = m;
        r.len  = l;
        return r;
    endfunction

    // Expected pin waveform: each symbol is len carrier periods, each period
    // HIGH cycles of carrier (if marked) then silence; len 0 is a single low cycle.
    function automatic void build_wave(input sym_t s[$], input int count);
        exp_wave.delete();
        for (int i = 0; i < count; i++) begin
            if (s[i].len == 0) begin
                exp_wave.push_back(1'b0);
            end else begin
                for (int p = 0; p < s[i].len; p++) begin
                    for (int c = 0; c < DIV; c++) begin
                        exp_wave.push_back(s[i].mark && (c < HIGH));
                    end
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: offer the head of push_q, retire it if accepted, settle past the edge.
    task automatic step();
        logic rdy;
        in_valid = (push_q.size() != 0);
        if (in_valid) begin
            in_mark = push_q[0].mark;
            in_len  = DUR_W'(push_q[0].len);
        end
        rdy = in_ready;
        @(posedge clk);
        if (in_valid && rdy) begin
            void'(push_q.pop_front());
        end
        #1;
        in_valid = 1'b0;
    endtask

    // exp_wave must appear on out starting after edge number lat.
    task automatic run(input string tag, input int lat, input int nsym,
                       input bit exp_busy, input int drop_at, input int tail);
        int n;
        int done_cnt;
        bit e;
        n        = lat + exp_wave.size() + tail;
        done_cnt = 0;
        for (int c = 0; c < n; c++) begin
            if (c == drop_at) begin
                enable = 1'b0;
            end
            step();
            e = (c >= lat && (c - lat) < exp_wave.size()) ? exp_wave[c - lat] : 1'b0;
            check($sformatf("%s.out[%0d]", tag, c), 32'(out), 32'(e));
            if (sym_done) begin
                done_cnt++;
            end
        end
        check({tag, ".sym_done_cnt"}, done_cnt, nsym);
        check({tag, ".busy_end"}, 32'(busy), 32'(exp_busy));
        check({tag, ".pending"}, push_q.size(), 0);
        $display("run %s: cycles=%0d sym_done=%0d checks=%0d failures=%0d",
                 tag, n, done_cnt, checks, failures);
    endtask

    initial begin
        sym_t tmp[$];
        int   n;
        bit   seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset.out", 32'(out), 0);
        check("reset.sym_done", 32'(sym_done), 0);
        check("reset.busy", 32'(busy), 0);
        check("reset.in_ready", 32'(in_ready), 1);
        #2;
        rst_n = 1'b1;

        enable = 1'b1;
        push_q.push_back(mk(1'b1, 3));
        build_wave(push_q, 1);
        run("single", 2, 1, 1'b0, -1, 3);

        push_q.push_back(mk(1'b1, 2));
        push_q.push_back(mk(1'b0, 4));
        push_q.push_back(mk(1'b1, 1));
        build_wave(push_q, 3);
        run("queue3", 2, 3, 1'b0, -1, 3);

        enable = 1'b0;
        push_q.push_back(mk(1'b1, 1));
        push_q.push_back(mk(1'b0, 1));
        push_q.push_back(mk(1'b1, 2));
        push_q.push_back(mk(1'b1, 0));
        push_q.push_back(mk(1'b1, 1));
        build_wave(push_q, 5);
        for (int i = 0; i < 6; i++) begin
            step();
        end
        check("fill.in_ready", 32'(in_ready), 0);
        check("fill.held", push_q.size(), 1);
        check("fill.busy", 32'(busy), 1);
        check("fill.out", 32'(out), 0);
        enable = 1'b1;
        run("drain5", 1, 5, 1'b0, -1, 3);

        push_q.push_back(mk(1'b1, 5));
        push_q.push_back(mk(1'b1, 1));
        build_wave(push_q, 1);
        run("en_off", 2, 1, 1'b1, 20, 20);
        tmp.delete();
        tmp.push_back(mk(1'b1, 1));
        build_wave(tmp, 1);
        enable = 1'b1;
        run("en_on", 1, 1, 1'b0, -1, 3);

        push_q.push_back(mk(1'b1, 1));
        push_q.push_back(mk(1'b1, 0));
        push_q.push_back(mk(1'b1, 1));
        build_wave(push_q, 3);
        run("zero_len", 2, 3, 1'b0, -1, 3);

        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
                push_q.push_back(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 3))));
            end
            build_wave(push_q, n);
            run($sformatf("rnd%0d", f), 2, n, 1'b0, -1, 3);
        end

        push_q.push_back(mk(1'b1, 3));
        push_q.push_back(mk(1'b0, 2));
        push_q.push_back(mk(1'b1, 2));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = (out === 1'b1);
        end
        check("rst.burst_seen", 32'(seen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.out", 32'(out), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.in_ready", 32'(in_ready), 1);
        check("rst.sym_done", 32'(sym_done), 0);
        push_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        exp_wave.delete();
        run("post_rst", 0, 0, 1'b0, -1, 40);
        push_q.push_back(mk(1'b1, 1));
        build_wave(push_q, 1);
        run("after_rst", 2, 1, 1'b0, -1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_modulator_tx.md
# ir_modulator_tx

Parametrised infrared transmitter: generates a carrier of configurable frequency and duty cycle and gates it with a queue of mark/space symbols, each lasting a programmed number of carrier periods. Software or a protocol encoder (NEC, RC5) pushes symbols through a valid/ready port. The block drives the IR LED pin directly, so no CPU timing is needed once a frame is queued.

## Interface
- CLOCK_SPEED, 8000000: clk frequency in Hz.
- CARRIER_HZ, 38000: carrier frequency in Hz.
- DUTY_PCT, 33: carrier high time in percent, 1..99.
- DUR_W, 16: width of a symbol length field.
- FIFO_DEPTH, 4: symbol queue depth; power of two, at least 2.

- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  allows the engine to start new symbols.
- in_valid  in  1  symbol offered.
- in_ready  out  1  queue can accept; equals not-full.
- in_mark  in  1  1 = carrier burst, 0 = silence.
- in_len  in  DUR_W  symbol length in carrier periods.
- sym_done  out  1  one-cycle pulse when a symbol finishes.
- busy  out  1  symbol running or queue non-empty.
- out  out  1  modulated output, registered.

## Operation
- Derived constants:
  - DIV = CLOCK_SPEED / CARRIER_HZ, truncating.
  - HIGH = DIV * DUTY_PCT / 100, truncating.
  - Elaboration error if DIV < 2 or HIGH < 1.
- Carrier counter cnt runs 0..DIV-1. It is cleared at every symbol load, so every symbol starts at carrier phase 0.
- Period counter per runs 0..in_len-1 and advances when cnt wraps.
- Engine FSM:
  - IDLE -> RUN when enable = 1 and the queue is non-empty. This pops the head and clears cnt and per.
  - RUN, last cycle (per == len-1 and cnt == DIV-1): assert sym_done.
    - If enable = 1 and the queue is non-empty, pop the next symbol and stay in RUN with no gap.
    - Otherwise go to IDLE.
  - Zero-length symbol: popped, spends exactly 1 cycle in RUN, out stays 0, sym_done still pulses.
- Output register:
  - In RUN: out <= mark && (cnt < HIGH).
  - In IDLE: out <= 0.
- enable deasserted mid-symbol: the current symbol completes and no further pop occurs. It has no effect on queue writes.
- Queue write occurs when in_valid && in_ready.
- Simultaneous push and pop on a full queue: the push is not accepted, because in_ready is 0 that cycle.
- Queue pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an extra pointer bit.

## Timing
- Reset values: out = 0, sym_done = 0, busy = 0, FSM = IDLE, queue empty, in_ready = 1.
- Reset asserted mid-symbol: out drops to 0 asynchronously and queue contents are discarded.
- Latency from an accepting edge E0 into an empty queue with enable high:
  - pop on E1;
  - out reflects cnt = 0 after E2.
- Symbol occupancy: out carries each symbol for exactly len*DIV cycles. A zero-length symbol occupies 1 cycle.
- Back-to-back symbols are contiguous on out.
- sym_done is high during the last RUN cycle of the symbol.
- busy is combinational: (state == RUN) or queue non-empty.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, RUN);
  - a function computing DIV and HIGH from the parameters;
  - the symbol record type {mark, len}.
- One sub-module, ir_sym_fifo: a synchronous FIFO, width DUR_W+1, depth FIFO_DEPTH, with full/empty flags and a show-ahead head.
- The carrier counter, period counter and FSM live in the top module.

## Test plan
Bench parameters: CLOCK_SPEED = 1000, CARRIER_HZ = 100, DUTY_PCT = 30, so DIV = 10 and HIGH = 3.
- Reset, then one symbol (mark = 1, len = 3) -> out pattern 1,1,1,0×7 repeated 3 times; first high 2 cycles after acceptance; 30 cycles total; sym_done once; busy drops afterwards.
- Queue {1,2}, {0,4}, {1,1} -> 20 cycles of burst, 40 cycles of 0, 10 cycles of burst; no gaps; 3 sym_done pulses.
- Push 5 symbols with enable = 0 -> in_ready = 0 after 4 accepted; the 5th is held; raising enable drains all 5 in order.
- Drop enable mid-symbol of {1,5} with another queued -> current symbol completes; out stays 0 afterwards; the queued symbol is not popped until enable returns.
- Symbol {1,0} between two {1,1} -> 1-cycle gap with out = 0; 3 sym_done pulses.
- Assert rst_n low during a burst -> out = 0 immediately; busy = 0; in_ready = 1 after release; the old queue contents are never emitted.
